// File: rtl/delay_button_control_if.sv
// rtl/delay_button_control_if.sv - button inputs and delay setting outputs of the delay button controller
interface delay_button_control_if #(
  parameter int DELAY_WIDTH = 8
);
  logic                   btn_up;
  logic                   btn_down;
  logic                   btn_center;
  logic [DELAY_WIDTH-1:0] delay_value;
  logic                   delay_update;

  modport master (
    output btn_up,
    output btn_down,
    output btn_center,
    input  delay_value,
    input  delay_update
  );

  modport slave (
    input  btn_up,
    input  btn_down,
    input  btn_center,
    output delay_value,
    output delay_update
  );
endinterface

// File: rtl/delay_button_control.sv
// rtl/delay_button_control.sv - steps a clamped delay setting from debounced buttons with hold-to-repeat
// Buttons are sampled only at the clock edge; delay_value and delay_update are plain registers.
module delay_button_control #(
  parameter int DELAY_WIDTH   = 8,
  parameter int DELAY_MAX     = 255,
  parameter int DELAY_DEFAULT = 0,
  parameter int STEP          = 1,
  parameter int HOLD_CYCLES   = 50000000,
  parameter int REPEAT_CYCLES = 10000000
) (
  input  logic                   clk,
  input  logic                   resetn,
  delay_button_control_if.slave  bus
);

  localparam int CNT_SPAN = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
  localparam int CNT_W    = $clog2(CNT_SPAN);

  localparam logic [DELAY_WIDTH:0]   STEP_X    = (DELAY_WIDTH+1)'(STEP);
  localparam logic [DELAY_WIDTH:0]   MAX_X     = (DELAY_WIDTH+1)'(DELAY_MAX);
  localparam logic [DELAY_WIDTH-1:0] DEF_V     = DELAY_WIDTH'(DELAY_DEFAULT);
  localparam logic [CNT_W-1:0]       HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0]       REP_LAST  = CNT_W'(REPEAT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HELD   = 2'd1,
    REPEAT = 2'd2,
    LOCKED = 2'd3
  } state_t;

  state_t                 state_q,  state_d;
  logic [CNT_W-1:0]       cnt_q,    cnt_d;
  logic                   dir_up_q, dir_up_d;
  logic [DELAY_WIDTH-1:0] value_q,  value_d;
  logic                   update_q, update_d;

  logic                   only_up, only_down, only_center, none_high;
  logic                   latched_high, other_high;
  logic                   step_en, load_en;
  logic [DELAY_WIDTH-1:0] load_val;

  // Sum is kept one bit wider so a step past DELAY_MAX clamps instead of wrapping.
  function automatic logic [DELAY_WIDTH-1:0] step_up(input logic [DELAY_WIDTH-1:0] v);
    logic [DELAY_WIDTH:0] sum;
    sum = {1'b0, v} + STEP_X;
    if (sum > MAX_X) begin
      return MAX_X[DELAY_WIDTH-1:0];
    end
    return sum[DELAY_WIDTH-1:0];
  endfunction

  function automatic logic [DELAY_WIDTH-1:0] step_down(input logic [DELAY_WIDTH-1:0] v);
    if ({1'b0, v} < STEP_X) begin
      return '0;
    end
    return v - STEP_X[DELAY_WIDTH-1:0];
  endfunction

  always_comb begin
    only_up      = bus.btn_up & ~bus.btn_down & ~bus.btn_center;
    only_down    = ~bus.btn_up & bus.btn_down & ~bus.btn_center;
    only_center  = ~bus.btn_up & ~bus.btn_down & bus.btn_center;
    none_high    = ~bus.btn_up & ~bus.btn_down & ~bus.btn_center;
    latched_high = dir_up_q ? bus.btn_up : bus.btn_down;
    other_high   = bus.btn_center | (dir_up_q ? bus.btn_down : bus.btn_up);
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    dir_up_d = dir_up_q;
    step_en  = 1'b0;
    load_en  = 1'b0;
    load_val = value_q;

    case (state_q)
      IDLE: begin
        if (only_up || only_down) begin
          dir_up_d = only_up;
          step_en  = 1'b1;
          cnt_d    = '0;
          state_d  = HELD;
        end else if (only_center) begin
          load_en  = 1'b1;
          load_val = DEF_V;
          state_d  = LOCKED;
        end else if (!none_high) begin
          state_d  = LOCKED;
        end
      end

      HELD, REPEAT: begin
        if (!latched_high || other_high) begin
          cnt_d   = '0;
          state_d = none_high ? IDLE : LOCKED;
        end else if (cnt_q == ((state_q == HELD) ? HOLD_LAST : REP_LAST)) begin
          step_en = 1'b1;
          cnt_d   = '0;
          state_d = REPEAT;
        end else begin
          cnt_d   = cnt_q + 1'b1;
        end
      end

      LOCKED: begin
        if (none_high) begin
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase

    // A step uses the direction chosen this cycle, so an IDLE press steps immediately.
    if (step_en) begin
      load_en  = 1'b1;
      load_val = dir_up_d ? step_up(value_q) : step_down(value_q);
    end

    value_d  = load_en ? load_val : value_q;
    update_d = load_en && (load_val != value_q);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      dir_up_q <= 1'b1;
      value_q  <= DEF_V;
      update_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      dir_up_q <= dir_up_d;
      value_q  <= value_d;
      update_q <= update_d;
    end
  end

  assign bus.delay_value  = value_q;
  assign bus.delay_update = update_q;

endmodule
